// File: rtl/topk_serializer.sv
// Streams a packed N-element vector out one element per handshake, index 0..N-1.
// Define TOPK_SERIALIZER_DOUBLE_BUF_EN to add a shadow buffer for gapless back-to-back vectors.
module topk_serializer #(
  parameter int DATA_WIDTH    = 32,
  parameter int LOG_INPUT_NUM = 4
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    i_valid,
  output logic                                    i_ready,
  input  logic [DATA_WIDTH*(2**LOG_INPUT_NUM)-1:0] x,
  output logic                                    o_valid,
  input  logic                                    o_ready,
  output logic [DATA_WIDTH-1:0]                   o_data,
  output logic [LOG_INPUT_NUM-1:0]                o_index,
  output logic                                    o_last
);

  localparam int N = 2**LOG_INPUT_NUM;
  localparam logic [LOG_INPUT_NUM-1:0] LAST_IDX = '1;

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  state_t                   state_q, state_d;
  logic [LOG_INPUT_NUM-1:0] idx_q, idx_d;
  logic [DATA_WIDTH-1:0]    main_q [N];
  logic                     load_main;

`ifdef TOPK_SERIALIZER_DOUBLE_BUF_EN
  logic [DATA_WIDTH-1:0]    shadow_q [N];
  logic                     shadow_full_q, shadow_full_d;
  logic                     load_shadow;
  logic                     swap_shadow;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      idx_q         <= '0;
`ifdef TOPK_SERIALIZER_DOUBLE_BUF_EN
      shadow_full_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
`ifdef TOPK_SERIALIZER_DOUBLE_BUF_EN
      shadow_full_q <= shadow_full_d;
`endif
    end
  end

  // NOTE: the vector buffers carry no reset; stale contents are never visible
  // because outputs are forced to zero outside STREAM and the valid/full flags reset.
  always_ff @(posedge clk) begin
    if (load_main) begin
      for (int k = 0; k < N; k++) main_q[k] <= x[DATA_WIDTH*k +: DATA_WIDTH];
    end
`ifdef TOPK_SERIALIZER_DOUBLE_BUF_EN
    else if (swap_shadow) begin
      for (int k = 0; k < N; k++) main_q[k] <= shadow_q[k];
    end
    if (load_shadow) begin
      for (int k = 0; k < N; k++) shadow_q[k] <= x[DATA_WIDTH*k +: DATA_WIDTH];
    end
`endif
  end

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    load_main     = 1'b0;
    i_ready       = 1'b0;
    o_valid       = 1'b0;
    o_data        = '0;
    o_index       = '0;
    o_last        = 1'b0;
`ifdef TOPK_SERIALIZER_DOUBLE_BUF_EN
    shadow_full_d = shadow_full_q;
    load_shadow   = 1'b0;
    swap_shadow   = 1'b0;
`endif

    // Reset gates the handshake outputs combinationally, before the flops clear.
    if (!rst) begin
      case (state_q)
        IDLE: begin
          i_ready = 1'b1;
          if (i_valid) begin
            load_main = 1'b1;
            idx_d     = '0;
            state_d   = STREAM;
          end
        end

        STREAM: begin
          o_valid = 1'b1;
          o_data  = main_q[idx_q];
          o_index = idx_q;
          o_last  = (idx_q == LAST_IDX);
`ifdef TOPK_SERIALIZER_DOUBLE_BUF_EN
          i_ready = !shadow_full_q;
`endif
          if (o_ready) begin
            if (idx_q != LAST_IDX) begin
              idx_d = idx_q + 1'b1;
            end else begin
              idx_d = '0;
`ifdef TOPK_SERIALIZER_DOUBLE_BUF_EN
              if (shadow_full_q) begin
                swap_shadow   = 1'b1;
                shadow_full_d = 1'b0;
              end else if (i_valid) begin
                load_main = 1'b1;  // new vector straight into main, no bubble
              end else begin
                state_d = IDLE;
              end
`else
              state_d = IDLE;
`endif
            end
          end
`ifdef TOPK_SERIALIZER_DOUBLE_BUF_EN
          if (i_valid && !shadow_full_q && !load_main) begin
            load_shadow   = 1'b1;
            shadow_full_d = 1'b1;
          end
`endif
        end

        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_topk_serializer.sv
// Self-checking bench for topk_serializer: a queue of pending output elements
// predicts every output, including i_ready, from the handshake rules alone.
module tb_topk_serializer;

  localparam int DW = 32;
  localparam int LG = 4;
  localparam int N  = 16;
  localparam int OW = DW + LG + 3;

  // Accept is allowed while no more than CAP elements are still pending.
`ifdef TOPK_SERIALIZER_DOUBLE_BUF_EN
  localparam int CAP = N;
`else
  localparam int CAP = 0;
`endif

  typedef struct packed {
    logic [DW-1:0] data;
    logic [LG-1:0] idx;
    logic          last;
  } elem_t;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            i_valid = 1'b0;
  logic            o_ready = 1'b0;
  logic [DW*N-1:0] x = '0;
  logic            i_ready;
  logic            o_valid;
  logic [DW-1:0]   o_data;
  logic [LG-1:0]   o_index;
  logic            o_last;

  int    tests_run = 0;
  int    tests_failed = 0;
  elem_t q[$];
  bit    m_acc, m_xfer;
  int    m_accepts = 0;

  topk_serializer #(.DATA_WIDTH(DW), .LOG_INPUT_NUM(LG)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready), .x(x),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data),
    .o_index(o_index), .o_last(o_last)
  );

  always #5 clk = ~clk;

  // Reference model: pending elements in emission order.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
    end else begin
      m_acc  = i_valid && (q.size() <= CAP);
      m_xfer = o_ready && (q.size() > 0);
      if (m_xfer) void'(q.pop_front());
      if (m_acc) begin
        m_accepts++;
        for (int k = 0; k < N; k++)
          q.push_back('{data: x[DW*k +: DW], idx: LG'(k), last: (k == N-1)});
      end
    end
  end

  function automatic logic [OW-1:0] observed();
    return {o_valid, i_ready, o_data, o_index, o_last};
  endfunction

  function automatic logic [OW-1:0] expected();
    logic rdy;
    if (rst) return '0;
    rdy = (q.size() <= CAP);
    if (q.size() == 0) return {1'b0, rdy, {DW{1'b0}}, {LG{1'b0}}, 1'b0};
    return {1'b1, rdy, q[0].data, q[0].idx, q[0].last};
  endfunction

  function automatic logic [DW*N-1:0] ramp_vec(input logic [DW-1:0] base);
    logic [DW*N-1:0] v;
    for (int k = 0; k < N; k++) v[DW*k +: DW] = base + DW'(k);
    return v;
  endfunction

  function automatic logic [DW*N-1:0] rand_vec();
    logic [DW*N-1:0] v;
    for (int k = 0; k < N; k++) v[DW*k +: DW] = $urandom;
    return v;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; i_valid = 1'b0; o_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [OW-1:0] want;
    @(negedge clk);
    rst = 1'b1; i_valid = 1'b1; o_ready = 1'b1; x = rand_vec();
    #1;
    tests_run++;
    if (observed() !== '0) begin
      tests_failed++;
      $display("FAIL reset_state: got %h want %h", observed(), {OW{1'b0}});
    end
    @(negedge clk);
    rst = 1'b0; i_valid = 1'b0;
    #1;
    want = {1'b0, 1'b1, {DW{1'b0}}, {LG{1'b0}}, 1'b0};
    tests_run++;
    if (observed() !== want) begin
      tests_failed++;
      $display("FAIL reset_release: got %h want %h", observed(), want);
    end
  endtask

  task automatic test_single();
    int xfers = 0;
    apply_reset();
    x = ramp_vec(32'h3F800000); i_valid = 1'b1; o_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      tests_run++;
      if (observed() !== expected()) begin
        tests_failed++;
        $display("FAIL single cyc %0d: got %h want %h", c, observed(), expected());
      end
      if (o_valid && o_ready) xfers++;
      i_valid = 1'b0;
    end
    tests_run++;
    if (xfers !== N) begin
      tests_failed++;
      $display("FAIL single_count: got %0d want %0d", xfers, N);
    end
  endtask

  task automatic test_backpressure();
    int stall = 0;
    bit stalled = 1'b0;
    apply_reset();
    x = ramp_vec(32'h3F800000); i_valid = 1'b1; o_ready = 1'b1;
    for (int c = 0; c < 26; c++) begin
      @(negedge clk);
      tests_run++;
      if (observed() !== expected()) begin
        tests_failed++;
        $display("FAIL backpressure cyc %0d: got %h want %h", c, observed(), expected());
      end
      if (stalled) begin
        tests_run++;
        if ({o_valid, o_data, o_index} !== {1'b1, 32'h3F800003, 4'd3}) begin
          tests_failed++;
          $display("FAIL bp_hold cyc %0d: got %b/%h/%0d want 1/3f800003/3", c, o_valid, o_data, o_index);
        end
      end
      i_valid = 1'b0;
      stalled = (q.size() > 0) && (q[0].idx == 4'd3) && (stall < 4);
      if (stalled) stall++;
      o_ready = !stalled;
    end
  endtask

  task automatic test_back_to_back();
    logic [DW*N-1:0] vecs [3];
    int base;
    vecs[0] = ramp_vec(32'h40000000);
    vecs[1] = ramp_vec(32'hC0000000);
    vecs[2] = rand_vec();
    apply_reset();
    base = m_accepts;
    x = vecs[0]; i_valid = 1'b1; o_ready = 1'b1;
    for (int c = 0; c < 3*(N+1)+10; c++) begin
      @(negedge clk);
      tests_run++;
      if (observed() !== expected()) begin
        tests_failed++;
        $display("FAIL back_to_back cyc %0d: got %h want %h", c, observed(), expected());
      end
      i_valid = (m_accepts - base) < 3;
      if (i_valid) x = vecs[m_accepts - base];
    end
    tests_run++;
    if (m_accepts - base !== 3) begin
      tests_failed++;
      $display("FAIL b2b_accepts: got %0d want 3", m_accepts - base);
    end
  endtask

  task automatic test_reset_midstream();
    bit found = 1'b0;
    apply_reset();
    x = rand_vec(); i_valid = 1'b1; o_ready = 1'b1;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      tests_run++;
      if (observed() !== expected()) begin
        tests_failed++;
        $display("FAIL midreset_pre cyc %0d: got %h want %h", c, observed(), expected());
      end
      i_valid = 1'b0;
      if (q.size() > 0 && q[0].idx == 4'd5) found = 1'b1;
    end
    tests_run++;
    if (!found) begin
      tests_failed++;
      $display("FAIL midreset_reach: index 5 not reached want reached");
    end else begin
      #1 rst = 1'b1;
      #1;
      tests_run++;
      if (observed() !== '0) begin
        tests_failed++;
        $display("FAIL midreset_state: got %h want %h", observed(), {OW{1'b0}});
      end
      @(negedge clk);
      rst = 1'b0; x = rand_vec(); i_valid = 1'b1;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        tests_run++;
        if (observed() !== expected()) begin
          tests_failed++;
          $display("FAIL midreset_post cyc %0d: got %h want %h", c, observed(), expected());
        end
        if (c == 0) begin
          tests_run++;
          if ({o_valid, o_index} !== {1'b1, 4'd0}) begin
            tests_failed++;
            $display("FAIL midreset_restart: got %b/%0d want 1/0", o_valid, o_index);
          end
        end
        i_valid = 1'b0;
      end
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      tests_run++;
      if (observed() !== expected()) begin
        tests_failed++;
        $display("FAIL random cyc %0d: got %h want %h", c, observed(), expected());
      end
      i_valid = ($urandom_range(0, 1) == 1);
      o_ready = ($urandom_range(0, 3) != 0);
      x = rand_vec();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_reset_midstream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
